// File: rtl/note_env_pkg.sv
// Shared types and constants for the note gain envelope.
package note_env_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ATTACK  = 2'd1,
      SUSTAIN = 2'd2,
      RELEASE = 2'd3
   } env_state_t;

   localparam int unsigned SAMPLE_W_DEF     = 10;
   localparam int unsigned GAIN_W_DEF       = 8;
   localparam int unsigned OUT_W_DEF        = 32;
   localparam int unsigned NOTE_W           = 4;
   localparam int unsigned ATTACK_STEP_DEF  = 8;
   localparam int unsigned RELEASE_STEP_DEF = 4;

   localparam logic [NOTE_W-1:0] NOTE_SILENT = 4'd0;
   localparam logic [7:0]        GAIN_MAX    = 8'd255;

endpackage

// File: rtl/env_gain_mult.sv
// Combinational signed sample times unsigned gain, left-justified to OUT_W.
module env_gain_mult #(
   parameter int unsigned SAMPLE_W = 10,
   parameter int unsigned GAIN_W   = 8,
   parameter int unsigned OUT_W    = 32
) (
   input  logic [SAMPLE_W-1:0] sample,
   input  logic [GAIN_W-1:0]   gain,
   output logic [OUT_W-1:0]    out_sample_c
);

   localparam int unsigned PROD_W = SAMPLE_W + GAIN_W;

   logic signed [PROD_W-1:0] sample_ext;
   logic signed [PROD_W-1:0] gain_ext;
   logic signed [PROD_W-1:0] prod;

   // Gain is zero-extended so it always multiplies as a positive value.
   assign sample_ext   = PROD_W'($signed(sample));
   assign gain_ext     = $signed(PROD_W'(gain));
   assign prod         = sample_ext * gain_ext;
   assign out_sample_c = {prod, {(OUT_W-PROD_W){1'b0}}};

endmodule

// File: rtl/note_envelope.sv
// Attack/sustain/release gain envelope between note selector and audio controller.
// Optional debug outputs dbg_state/dbg_gain when NOTE_ENVELOPE_DEBUG_EN is defined.
module note_envelope
   import note_env_pkg::*;
#(
   parameter int unsigned SAMPLE_W     = SAMPLE_W_DEF,
   parameter int unsigned GAIN_W       = GAIN_W_DEF,
   parameter int unsigned ATTACK_STEP  = ATTACK_STEP_DEF,
   parameter int unsigned RELEASE_STEP = RELEASE_STEP_DEF,
   parameter int unsigned OUT_W        = OUT_W_DEF
) (
   input  logic                clock,
   input  logic                resetn,
   input  logic                in_valid,
   input  logic [SAMPLE_W-1:0] in_sample,
   input  logic [NOTE_W-1:0]   note_id,
   input  logic                out_ready,
   output logic                out_valid,
   output logic [OUT_W-1:0]    out_sample
`ifdef NOTE_ENVELOPE_DEBUG_EN
   ,
   output logic [1:0]          dbg_state,
   output logic [GAIN_W-1:0]   dbg_gain
`endif
);

   localparam logic [GAIN_W-1:0] GAIN_FULL = GAIN_W'(GAIN_MAX);

   env_state_t          state, state_nxt;
   logic [GAIN_W-1:0]   gain, gain_nxt;
   logic [NOTE_W-1:0]   cur_note, note_nxt;
   logic                accept;
   logic [GAIN_W:0]     att_sum;
   logic [GAIN_W-1:0]   att_gain;
   logic [GAIN_W-1:0]   rel_gain;
   logic [OUT_W-1:0]    mult_c;

   assign accept = in_valid & out_ready;

   env_gain_mult #(
      .SAMPLE_W (SAMPLE_W),
      .GAIN_W   (GAIN_W),
      .OUT_W    (OUT_W)
   ) u_mult (
      .sample       (in_sample),
      .gain         (gain),
      .out_sample_c (mult_c)
   );

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nxt;
   end

   // Next state plus saturating gain; transition checks win over saturation.
   always_comb begin
      state_nxt = state;
      gain_nxt  = gain;
      note_nxt  = cur_note;
      att_sum   = (GAIN_W+1)'(gain) + (GAIN_W+1)'(ATTACK_STEP);
      att_gain  = (att_sum >= (GAIN_W+1)'(GAIN_FULL)) ? GAIN_FULL : att_sum[GAIN_W-1:0];
      rel_gain  = (gain >= GAIN_W'(RELEASE_STEP)) ? (gain - GAIN_W'(RELEASE_STEP)) : '0;
      if (accept) begin
         case (state)
            IDLE: begin
               // The note-on sample counts as the first attack step.
               if (note_id != NOTE_SILENT) begin
                  note_nxt  = note_id;
                  gain_nxt  = att_gain;
                  state_nxt = (att_gain == GAIN_FULL) ? SUSTAIN : ATTACK;
               end
            end
            ATTACK: begin
               if (note_id == NOTE_SILENT || note_id != cur_note) begin
                  state_nxt = RELEASE;
               end else begin
                  gain_nxt = att_gain;
                  if (att_gain == GAIN_FULL) state_nxt = SUSTAIN;
               end
            end
            SUSTAIN: begin
               if (note_id == NOTE_SILENT || note_id != cur_note) state_nxt = RELEASE;
            end
            RELEASE: begin
               if (note_id == cur_note && note_id != NOTE_SILENT) begin
                  state_nxt = ATTACK;
               end else begin
                  gain_nxt = rel_gain;
                  if (rel_gain == '0) begin
                     if (note_id != NOTE_SILENT) begin
                        note_nxt  = note_id;
                        state_nxt = ATTACK;
                     end else begin
                        state_nxt = IDLE;
                     end
                  end
               end
            end
         endcase
      end
   end

   // Datapath registers; the product uses the gain before this sample's update.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         gain       <= '0;
         cur_note   <= NOTE_SILENT;
         out_valid  <= 1'b0;
         out_sample <= '0;
      end else begin
         gain      <= gain_nxt;
         cur_note  <= note_nxt;
         out_valid <= accept;
         if (accept) out_sample <= mult_c;
      end
   end

`ifdef NOTE_ENVELOPE_DEBUG_EN
   assign dbg_state = state;
   assign dbg_gain  = gain;
`endif

endmodule

// File: tb/tb_note_envelope.sv
// Directed vector table plus hand sequences for note_envelope.
module tb_note_envelope;

   logic        clock     = 1'b0;
   logic        resetn    = 1'b0;
   logic        in_valid  = 1'b0;
   logic [9:0]  in_sample = '0;
   logic [3:0]  note_id   = '0;
   logic        out_ready = 1'b0;
   logic        out_valid;
   logic [31:0] out_sample;

   int total = 0;
   int bad   = 0;
   logic [31:0] hold = '0;

   always #10 clock = ~clock;

   note_envelope dut (
      .clock      (clock),
      .resetn     (resetn),
      .in_valid   (in_valid),
      .in_sample  (in_sample),
      .note_id    (note_id),
      .out_ready  (out_ready),
      .out_valid  (out_valid),
      .out_sample (out_sample)
   );

   typedef struct {
      logic        v;
      logic        r;
      logic [3:0]  n;
      int          s;
      logic        ev;
      logic [31:0] es;
   } vec_t;

   vec_t tbl[$];

   // Expected enveloped sample for a given sample and pre-update gain.
   function automatic logic [31:0] fx(input int s, input int g);
      logic [31:0] p;
      p = 32'(s * g);
      return p << 14;
   endfunction

   task automatic check_now(input logic ev, input logic [31:0] es, input string name);
      total++;
      if (out_valid !== ev || out_sample !== es) begin
         bad++;
         $display("FAIL %s: got valid=%0b sample=%h, want valid=%0b sample=%h",
                  name, out_valid, out_sample, ev, es);
      end
   endtask

   task automatic drive_check(input logic v, input logic r, input logic [3:0] n, input int s,
                              input logic ev, input logic [31:0] es, input string name);
      in_valid  = v;
      out_ready = r;
      note_id   = n;
      in_sample = 10'(s);
      @(posedge clock);
      #1;
      check_now(ev, es, name);
   endtask

   // g is the gain the envelope should hold before this sample.
   task automatic step(input logic v, input logic r, input logic [3:0] n, input int s,
                       input int g, input string name);
      if (v && r) hold = fx(s, g);
      drive_check(v, r, n, s, v & r, hold, name);
   endtask

   task automatic push(input logic v, input logic r, input logic [3:0] n, input int s, input int g);
      vec_t x;
      x.v = v; x.r = r; x.n = n; x.s = s;
      if (v && r) hold = fx(s, g);
      x.ev = v & r;
      x.es = hold;
      tbl.push_back(x);
   endtask

   task automatic do_reset();
      resetn    = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      note_id   = '0;
      in_sample = '0;
      repeat (2) @(posedge clock);
      #1;
      check_now(1'b0, 32'd0, "reset");
      resetn = 1'b1;
      hold   = '0;
      @(posedge clock);
      #1;
   endtask

   task automatic ramp(input logic [3:0] n, input int s, input int k0, input int k1, input string name);
      for (int k = k0; k <= k1; k++) step(1, 1, n, s, (8 * k > 255) ? 255 : 8 * k, name);
   endtask

   initial begin
      do_reset();

      hold = '0;
      push(1, 1, 0, 200, 0);
      push(0, 1, 0, 0, 0);
      push(1, 0, 1, 100, 0);
      push(1, 1, 3, 100, 0);
      push(1, 1, 3, -100, 8);
      push(0, 1, 5, 50, 0);
      push(1, 1, 3, 511, 16);
      push(1, 1, 0, -512, 24);
      push(1, 1, 3, 100, 24);
      push(1, 1, 3, 100, 24);
      push(1, 1, 7, 100, 32);
      for (int g = 32; g >= 4; g -= 4) push(1, 1, 7, 100, g);
      push(1, 1, 7, 100, 0);
      push(1, 1, 7, -1, 8);
      push(1, 1, 0, 77, 16);
      for (int g = 16; g >= 4; g -= 4) push(1, 1, 0, 77, g);
      push(1, 1, 0, 100, 0);
      push(1, 1, 0, 100, 0);
      for (int i = 0; i < tbl.size(); i++)
         drive_check(tbl[i].v, tbl[i].r, tbl[i].n, tbl[i].s, tbl[i].ev, tbl[i].es, $sformatf("vec%0d", i));

      // Ramp with a 20-cycle stall, sustain, then release to silence.
      do_reset();
      ramp(1, 256, 0, 9, "ramp_pre");
      for (int i = 0; i < 20; i++) step(1, 0, 1, 256, 0, "stall");
      ramp(1, 256, 10, 35, "ramp_post");
      step(1, 1, 0, 256, 255, "rel_enter");
      for (int g = 255; g >= 3; g -= 4) step(1, 1, 0, 256, g, "rel_ramp");
      step(1, 1, 0, 256, 0, "rel_idle");
      step(1, 1, 0, 256, 0, "rel_idle2");

      // Note change from sustain: full release then attack of the new note.
      do_reset();
      ramp(1, 256, 0, 33, "chg_ramp");
      step(1, 1, 5, 256, 255, "chg_enter");
      for (int g = 255; g >= 3; g -= 4) step(1, 1, 5, 256, g, "chg_rel");
      step(1, 1, 5, 256, 0, "chg_att0");
      step(1, 1, 5, 256, 8, "chg_att1");
      step(1, 1, 5, -256, 16, "chg_att2");

      // Note change on the sample that would saturate goes to release.
      do_reset();
      ramp(1, 256, 0, 30, "sat_ramp");
      step(1, 1, 2, 256, 248, "sat_chg");
      step(1, 1, 2, 256, 248, "sat_rel1");
      step(1, 1, 2, 256, 244, "sat_rel2");

      // Asynchronous reset in sustain clears outputs immediately.
      do_reset();
      ramp(1, 256, 0, 33, "ar_ramp");
      #4;
      resetn = 1'b0;
      #1;
      check_now(1'b0, 32'd0, "ar_clear");
      in_valid = 1'b0;
      #5;
      resetn = 1'b1;
      hold   = '0;
      step(1, 1, 0, 256, 0, "ar_idle");
      step(1, 1, 1, 256, 0, "ar_att0");
      step(1, 1, 1, 256, 8, "ar_att1");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/note_envelope.md
Name: note_envelope

Overview:
- Sits directly downstream of the note selector and upstream of the audio controller's write port.
- Takes the selected 10-bit note sample stream and its note code, and applies an attack/sustain/release gain envelope. This removes clicks on note start, stop and change.
- Emits a 32-bit left-justified sample and a one-cycle write strobe gated by the controller's output-allowed level.

Parameters:
- SAMPLE_W, 10, input sample width (two's complement)
- GAIN_W, 8, envelope gain width (unsigned, full scale 2^GAIN_W-1 = 255)
- ATTACK_STEP, 8, gain increment per accepted sample in ATTACK
- RELEASE_STEP, 4, gain decrement per accepted sample in RELEASE
- OUT_W, 32, output sample width

Ports:
- clock  in  1  system clock (50 MHz)
- resetn  in  1  asynchronous active-low reset
- in_valid  in  1  sample strobe from note selector
- in_sample  in  SAMPLE_W  signed note sample
- note_id  in  4  current note code; 0 = silence, 1..13 = C4..C5
- out_ready  in  1  audio controller output-allowed level
- out_valid  out  1  write strobe to audio controller
- out_sample  out  OUT_W  enveloped sample, same value drives left and right channels

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: out_valid=0, out_sample=0, gain=0, cur_note=0, state=IDLE.
- Accept condition: accept = in_valid & out_ready.
  - All state, gain and note updates happen only on accept cycles.
  - Non-accept cycles hold every register except out_valid.
- Latency: one cycle.
  - out_valid <= accept, so it is a single-cycle pulse per accepted sample.
  - out_sample updates only on accept and holds otherwise.
- Arithmetic:
  - prod = signed(in_sample) x unsigned(gain), 18-bit signed.
  - out_sample = {prod[17:0], 14'b0}.
  - The gain used is the pre-update value for that sample.
- Gain saturation:
  - ATTACK: gain = min(gain+ATTACK_STEP, 255).
  - RELEASE: gain = max(gain-RELEASE_STEP, 0).
- States and transitions (evaluated on accept):
  - IDLE (gain 0):
    - note_id!=0 -> latch cur_note=note_id, go to ATTACK.
    - Otherwise stay; samples are still emitted with value 0.
  - ATTACK:
    - note_id==0, or note_id!=cur_note -> RELEASE.
    - Otherwise increment gain; if the new gain is 255 -> SUSTAIN.
  - SUSTAIN (gain 255):
    - note_id==0, or note_id!=cur_note -> RELEASE.
  - RELEASE:
    - note_id==cur_note and !=0 -> ATTACK, continuing from the current gain.
    - Otherwise decrement gain. When the new gain is 0:
      - note_id!=0 -> latch cur_note=note_id, go to ATTACK.
      - else -> IDLE.
- Note change: always releases fully to 0 before attacking the new note. No hard gain jumps.
- Simultaneous events:
  - Transition checks take priority over the saturation-reached check in the same accept.
  - A note change on the exact sample gain hits 255 goes to RELEASE, not SUSTAIN.
- out_ready dropping the cycle after accept does not cancel out_valid; the controller FIFO absorbs it.
- Reset mid-operation: immediate clear to the reset values. The next output is 0 until a new attack begins.

Optional Feature:
- Macro: NOTE_ENVELOPE_DEBUG_EN.
- Defined: adds outputs dbg_state[1:0] (IDLE=0, ATTACK=1, SUSTAIN=2, RELEASE=3) and dbg_gain[7:0], driven directly from the registers, for LEDR/HEX display.
- Undefined: ports absent; core behaviour is identical.

Decomposition:
- Package note_env_pkg holds:
  - state enum (IDLE/ATTACK/SUSTAIN/RELEASE)
  - NOTE_SILENT=4'd0
  - GAIN_MAX=8'd255
  - default step constants
- Sub-module env_gain_mult: combinational signed-by-unsigned multiply plus left-justify to OUT_W. The parent registers its result.

Test Plan:
- Reset, then out_ready=1, in_valid pulsed, note_id=0, in_sample=10'sd200 -> out_valid pulses 1 cycle after each accept, out_sample=0, state IDLE.
- note_id=1, in_sample=10'sd256 constant, every cycle accepted -> gain 0,8,16..248,255; first out_sample=0, second=256x8<<14; SUSTAIN after 32 accepts; then out_sample=(256x255)<<14.
- From SUSTAIN set note_id=0 -> gain falls by 4 per accept, reaching 0 after 64 accepts -> IDLE, out_sample=0.
- From SUSTAIN change note_id 1->5 -> RELEASE to 0 (64 accepts), cur_note=5, then ATTACK; no output step larger than one gain step.
- Hold out_ready=0 with in_valid=1 for 20 cycles mid-ATTACK -> out_valid stays 0 and gain is frozen; resume -> ramp continues from the frozen gain.
- Assert resetn=0 asynchronously mid-SUSTAIN -> outputs are 0 in the same cycle; after release of reset the state is IDLE and gain is 0.
